gray_ptr_rx: RTL and testbench

GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

---
 rtl/gray_ptr_rx.sv | 157 +++++++++++++++
 tb/tb_gray_ptr_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: receives a gray-coded pointer from a gray counter in another part of the design,
// decodes it to binary and checks that successive samples move by at most one position.
//
// Ports:
//   i_clk        - clock, all state updates on its rising edge
//   i_rstn       - synchronous active-low reset
//   i_gray       - gray-coded pointer, sampled when i_en=1
//   i_en         - qualifies i_gray
//   i_clr_err    - clears error state and re-primes the tracker
//   o_bin        - binary decode of the most recently processed sample
//   o_valid      - one-cycle pulse: o_bin/o_step/o_dir/o_err were updated
//   o_step       - pulse: pointer moved by exactly +1 or -1 (modulo 2^BW_DATA)
//   o_dir        - direction of the last step (0 up, 1 down), held otherwise
//   o_err        - pulse: pointer moved by anything other than 0 or +/-1
//   o_err_sticky - set by any o_err, held until i_clr_err or reset
//   o_err_cnt    - saturating count of o_err pulses
module gray_ptr_rx #(
   parameter int unsigned BW_DATA = 8
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic [BW_DATA-1:0] i_gray,
   input  logic               i_en,
   input  logic               i_clr_err,
   output logic [BW_DATA-1:0] o_bin,
   output logic               o_valid,
   output logic               o_step,
   output logic               o_dir,
   output logic               o_err,
   output logic               o_err_sticky,
   output logic [7:0]         o_err_cnt
);

   typedef enum logic [1:0] {StInit, StTrack, StLock} state_e;

   state_e             state_q, state_d;
   logic [BW_DATA-1:0] s1_gray_q, s1_gray_d;
   logic               s1_vld_q, s1_vld_d;
   logic [BW_DATA-1:0] ref_q, ref_d;
   logic [BW_DATA-1:0] bin_q, bin_d;
   logic               valid_q, valid_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;
   logic               err_q, err_d;
   logic               sticky_q, sticky_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [BW_DATA-1:0] new_bin;
   logic [BW_DATA-1:0] delta;
   logic               is_up, is_dn, is_hold;

   function automatic logic [BW_DATA-1:0] gray2bin(input logic [BW_DATA-1:0] g);
      logic [BW_DATA-1:0] b;
      b[BW_DATA-1] = g[BW_DATA-1];
      for (int k = int'(BW_DATA) - 2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   always_comb begin
      new_bin = gray2bin(s1_gray_q);
      delta   = new_bin - ref_q;
      is_up   = (delta == BW_DATA'(1));
      is_dn   = &delta;
      is_hold = (delta == '0);

      // Stage 1 capture
      s1_vld_d  = i_en;
      s1_gray_d = i_en ? i_gray : s1_gray_q;

      state_d  = state_q;
      ref_d    = ref_q;
      bin_d    = bin_q;
      valid_d  = 1'b0;
      step_d   = 1'b0;
      dir_d    = dir_q;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;

      if (s1_vld_q) begin
         bin_d   = new_bin;
         valid_d = 1'b1;
         ref_d   = new_bin;
         if (i_clr_err) begin
            // Clear wins: this sample becomes the new reference, no step/err judgement.
            state_d  = StTrack;
            sticky_d = 1'b0;
            cnt_d    = '0;
         end else begin
            case (state_q)
               StInit: state_d = StTrack;
               StTrack: begin
                  if (is_up || is_dn) begin
                     step_d = 1'b1;
                     dir_d  = is_dn;
                  end else if (!is_hold) begin
                     err_d   = 1'b1;
                     state_d = StLock;
                  end
               end
               StLock: begin
                  // Deltas are still judged, but steps are suppressed once locked.
                  if (!(is_up || is_dn || is_hold)) err_d = 1'b1;
               end
               default: state_d = StInit;
            endcase
            if (err_d) begin
               sticky_d = 1'b1;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
         end
      end else if (i_clr_err) begin
         state_d  = StInit;
         sticky_d = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= StInit;
         s1_gray_q <= '0;
         s1_vld_q  <= 1'b0;
         ref_q     <= '0;
         bin_q     <= '0;
         valid_q   <= 1'b0;
         step_q    <= 1'b0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         s1_gray_q <= s1_gray_d;
         s1_vld_q  <= s1_vld_d;
         ref_q     <= ref_d;
         bin_q     <= bin_d;
         valid_q   <= valid_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_bin        = bin_q;
   assign o_valid      = valid_q;
   assign o_step       = step_q;
   assign o_dir        = dir_q;
   assign o_err        = err_q;
   assign o_err_sticky = sticky_q;
   assign o_err_cnt    = cnt_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Self-checking bench for gray_ptr_rx (BW_DATA=8): directed scenarios followed by a randomized
// pointer walk, all checked every cycle against a behavioural model of the pointer tracker.
module tb_gray_ptr_rx;

   logic       clk;
   logic       rstn;
   logic [7:0] gray;
   logic       en;
   logic       clr;
   logic [7:0] bin;
   logic       valid, step, dir, err, sticky;
   logic [7:0] err_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model state
   logic       m_s1_vld = 1'b0;
   int         m_s1_bin = 0;
   bit         m_have_ref = 0;
   bit         m_locked = 0;
   int         m_ref = 0;
   int         m_bin = 0;
   bit         m_valid = 0, m_step = 0, m_dir = 0, m_err = 0, m_sticky = 0;
   int         m_cnt = 0;

   gray_ptr_rx #(.BW_DATA(8)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_gray       (gray),
      .i_en         (en),
      .i_clr_err    (clr),
      .o_bin        (bin),
      .o_valid      (valid),
      .o_step       (step),
      .o_dir        (dir),
      .o_err        (err),
      .o_err_sticky (sticky),
      .o_err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Binary bit k is the parity of all gray bits at or above k.
   function automatic int g2b(input logic [7:0] g);
      logic [7:0] b;
      logic [7:0] t;
      for (int k = 0; k < 8; k++) begin
         t    = g >> k;
         b[k] = ^t;
      end
      return int'(b);
   endfunction

   function automatic logic [7:0] b2g(input int b);
      logic [7:0] v;
      v = 8'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge(input logic e, input logic [7:0] g, input logic c, input logic r);
      int d;
      if (!r) begin
         m_s1_vld = 0; m_have_ref = 0; m_locked = 0; m_ref = 0; m_bin = 0;
         m_valid = 0; m_step = 0; m_dir = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
         return;
      end
      m_valid = 0; m_step = 0; m_err = 0;
      if (m_s1_vld) begin
         m_bin   = m_s1_bin;
         m_valid = 1;
         d       = (m_bin - m_ref + 256) % 256;
         if (c) begin
            m_have_ref = 1; m_locked = 0; m_sticky = 0; m_cnt = 0;
         end else if (!m_have_ref) begin
            m_have_ref = 1;
         end else if (d == 1 || d == 255) begin
            if (!m_locked) begin
               m_step = 1;
               m_dir  = (d == 255);
            end
         end else if (d != 0) begin
            m_err = 1; m_locked = 1; m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
         end
         m_ref = m_bin;
      end else if (c) begin
         m_have_ref = 0; m_locked = 0; m_sticky = 0; m_cnt = 0;
      end
      m_s1_vld = e;
      if (e) m_s1_bin = g2b(g);
   endtask

   // One clock: drive inputs, advance model at the edge, compare all outputs just after.
   task automatic cyc(input logic e, input logic [7:0] g, input logic c = 1'b0,
                      input logic r = 1'b1);
      en = e; gray = g; clr = c; rstn = r;
      @(posedge clk);
      model_edge(e, g, c, r);
      #1;
      check("valid", {7'd0, valid}, {7'd0, m_valid});
      check("bin", bin, 8'(m_bin));
      check("step", {7'd0, step}, {7'd0, m_step});
      check("dir", {7'd0, dir}, {7'd0, m_dir});
      check("err", {7'd0, err}, {7'd0, m_err});
      check("sticky", {7'd0, sticky}, {7'd0, m_sticky});
      check("err_cnt", err_cnt, 8'(m_cnt));
   endtask

   initial begin
      int cur;
      int r;
      int mv;
      logic e, c, rs;
      en = 0; gray = 0; clr = 0; rstn = 0;

      // Reset state
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("rst_valid", {7'd0, valid}, 8'd0);
      check("rst_cnt", err_cnt, 8'd0);

      // Priming and count-up
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h01);
      check("up_prime_step", {7'd0, step}, 8'd0);
      check("up_prime_valid", {7'd0, valid}, 8'd1);
      cyc(1'b1, 8'h03);
      cyc(1'b1, 8'h02);
      cyc(1'b1, 8'h06);
      cyc(1'b1, 8'h07);
      cyc(1'b0, 8'h00);
      check("up_bin5", bin, 8'd5);
      check("up_step5", {7'd0, step}, 8'd1);
      cyc(1'b0, 8'h00);
      check("idle_valid", {7'd0, valid}, 8'd0);

      // Hold
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'h03);
      cyc(1'b1, 8'h03);
      cyc(1'b0, 8'h00);
      check("hold_bin", bin, 8'd2);
      check("hold_step", {7'd0, step}, 8'd0);

      // Wrap
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'h80);
      cyc(1'b1, 8'h00);
      check("wrap_prime", bin, 8'd255);
      cyc(1'b1, 8'h80);
      check("wrap_up_step", {7'd0, step}, 8'd1);
      check("wrap_up_dir", {7'd0, dir}, 8'd0);
      cyc(1'b0, 8'h00);
      check("wrap_dn_step", {7'd0, step}, 8'd1);
      check("wrap_dn_dir", {7'd0, dir}, 8'd1);

      // Jump error, lock, then clear colliding with a sample
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'h01);
      cyc(1'b1, 8'h05);
      cyc(1'b1, 8'h07);
      check("jump_err", {7'd0, err}, 8'd1);
      check("jump_bin", bin, 8'd6);
      check("jump_cnt", err_cnt, 8'd1);
      cyc(1'b1, 8'h0F);
      check("lock_step", {7'd0, step}, 8'd0);
      check("lock_bin", bin, 8'd5);
      cyc(1'b1, 8'h0E, 1'b1);
      check("clr_bin", bin, 8'd10);
      check("clr_sticky", {7'd0, sticky}, 8'd0);
      check("clr_cnt", err_cnt, 8'd0);
      cyc(1'b0, 8'h00);
      check("clr_next_step", {7'd0, step}, 8'd1);
      check("clr_next_bin", bin, 8'd11);

      // Reset mid-stream
      cyc(1'b1, 8'h01);
      cyc(1'b1, 8'h01, 1'b0, 1'b0);
      check("rst_mid_valid", {7'd0, valid}, 8'd0);
      check("rst_mid_bin", bin, 8'd0);
      cyc(1'b0, 8'h00);
      check("rst_mid_drop", {7'd0, valid}, 8'd0);
      cyc(1'b1, 8'h03);
      cyc(1'b0, 8'h00);
      check("rst_prime_bin", bin, 8'd2);
      check("rst_prime_step", {7'd0, step}, 8'd0);

      // Randomized pointer walk with occasional jumps, clears and resets
      cur = 0;
      for (int i = 0; i < 600; i++) begin
         r  = int'($urandom_range(0, 99));
         rs = (r < 2) ? 1'b0 : 1'b1;
         c  = (r >= 2 && r < 8);
         e  = ($urandom_range(0, 9) != 0);
         mv = int'($urandom_range(0, 9));
         if (mv < 4)      cur = (cur + 1) % 256;
         else if (mv < 7) cur = (cur + 255) % 256;
         else if (mv == 9) cur = int'($urandom_range(0, 255));
         cyc(e, b2g(cur), c, rs);
      end

      // Push the error counter to saturation
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 262; i++) begin
         cyc(1'b1, b2g((i % 2) * 128));
      end
      cyc(1'b0, 8'h00);
      check("cnt_sat", err_cnt, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
